// File: rtl/systolic_drain.sv
// Purpose: snapshot the systolic array accumulators after a fixed compute latency, rescale/saturate/ReLU, stream row-major.
// Latency: first element valid in the cycle after edge start+LATENCY; one element per cycle thereafter.
// Backpressure: out_ready low holds the current element stable; the frame resumes when out_ready returns.
module systolic_drain #(
  parameter int N       = 16,
  parameter int AROW    = 3,
  parameter int BCOL    = 3,
  parameter int LATENCY = 9,
  parameter int FRAC    = 8,
  parameter int RELU    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [AROW-1:0][BCOL-1:0][2*N-1:0]     sys_array,
  output logic                                   busy,
  output logic [N-1:0]                           out_data,
  output logic [((AROW > 1) ? $clog2(AROW) : 1)-1:0] out_row,
  output logic [((BCOL > 1) ? $clog2(BCOL) : 1)-1:0] out_col,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last,
  output logic                                   done,
  output logic                                   overrun
);

  localparam int RW = (AROW > 1) ? $clog2(AROW) : 1;
  localparam int CW = (BCOL > 1) ? $clog2(BCOL) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Saturation bounds expressed in the 2N-bit accumulator domain and the N-bit output domain.
  localparam logic signed [2*N-1:0] SAT_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] SAT_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [N-1:0]   OUT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]   OUT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                           state, state_nxt;
  logic [LW-1:0]                    cnt, cnt_nxt;
  logic [RW-1:0]                    row, row_nxt;
  logic [CW-1:0]                    col, col_nxt;
  logic                             capture;
  logic                             done_nxt;
  logic                             hs;
  logic                             at_last;
  logic [AROW-1:0][BCOL-1:0][2*N-1:0] snap;

  logic signed [2*N-1:0]            acc_sel;
  logic signed [2*N-1:0]            shifted;
  logic signed [N-1:0]              res;

  assign busy      = (state != IDLE);
  assign out_valid = (state == STREAM);
  assign at_last   = (row == RW'(AROW-1)) && (col == CW'(BCOL-1));
  assign out_last  = out_valid && at_last;
  assign hs        = out_valid && out_ready;
  assign out_row   = row;
  assign out_col   = col;

  // Next-state, latency countdown and row-major index walk.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    col_nxt   = col;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT;
          cnt_nxt   = LW'(LATENCY-1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = STREAM;
          row_nxt   = '0;
          col_nxt   = '0;
        end else begin
          cnt_nxt = cnt - LW'(1);
        end
      end
      STREAM: begin
        if (hs) begin
          if (at_last) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
            done_nxt  = 1'b1;
          end else if (col == CW'(BCOL-1)) begin
            col_nxt = '0;
            row_nxt = row + RW'(1);
          end else begin
            col_nxt = col + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers; start outside IDLE only flags overrun and never restarts the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      row     <= '0;
      col     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      done  <= done_nxt;
      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Accumulator snapshot, taken only on the capture edge so the array is free for the next multiply.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap <= '0;
    end else if (capture) begin
      snap <= sys_array;
    end
  end

  // Rescale the selected accumulator: arithmetic shift, saturate to N bits, optional ReLU.
  always_comb begin
    acc_sel = snap[row][col];
    shifted = acc_sel >>> FRAC;
    if (shifted > SAT_MAX) begin
      res = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      res = OUT_MIN;
    end else begin
      res = shifted[N-1:0];
    end
    if ((RELU != 0) && res[N-1]) begin
      res = '0;
    end
    out_data = out_valid ? res : '0;
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: two instances (ReLU on / off) share stimulus.
// Expected values come from an arithmetic reference model of the rescale rules and a cycle-count schedule.
// Covers reset/idle, latency, ordering, saturation, backpressure, snapshot, overrun and reset mid-frame.
module tb_systolic_drain;

  localparam int N    = 16;
  localparam int AROW = 3;
  localparam int BCOL = 3;
  localparam int LAT  = 9;
  localparam int FRAC = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [2:0][2:0][31:0]     sys;
  logic                      out_ready;

  logic        busy1, valid1, last1, done1, ovr1;
  logic [15:0] data1;
  logic [1:0]  row1, col1;
  logic        busy0, valid0, last0, done0, ovr0;
  logic [15:0] data0;
  logic [1:0]  row0, col0;

  int errors = 0;
  int checks = 0;
  bit ovr_exp = 1'b0;

  always #5 clk = ~clk;

  systolic_drain #(.N(N), .AROW(AROW), .BCOL(BCOL), .LATENCY(LAT), .FRAC(FRAC), .RELU(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sys_array(sys), .busy(busy1),
    .out_data(data1), .out_row(row1), .out_col(col1), .out_valid(valid1),
    .out_ready(out_ready), .out_last(last1), .done(done1), .overrun(ovr1)
  );

  systolic_drain #(.N(N), .AROW(AROW), .BCOL(BCOL), .LATENCY(LAT), .FRAC(FRAC), .RELU(0)) u_dut_norelu (
    .clk(clk), .rst(rst), .start(start), .sys_array(sys), .busy(busy0),
    .out_data(data0), .out_row(row0), .out_col(col0), .out_valid(valid0),
    .out_ready(out_ready), .out_last(last0), .done(done0), .overrun(ovr0)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rescale: floor division by 2^FRAC, clamp to signed N-bit, optional ReLU.
  function automatic logic [15:0] model(input logic [31:0] acc, input bit relu);
    longint a = longint'($signed(acc));
    longint d = longint'(1) << FRAC;
    longint q = a / d;
    logic [63:0] qv;
    if (a < 0 && (a % d) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    qv = 64'(q);
    return qv[15:0];
  endfunction

  task automatic check_elem(input int r, input int c, input logic [2:0][2:0][31:0] arr);
    chk("valid", valid1, 1);
    chk("data_relu", data1, model(arr[r][c], 1'b1));
    chk("data_norelu", data0, model(arr[r][c], 1'b0));
    chk("row", row1, r);
    chk("col", col1, c);
    chk("last", last1, (r == AROW-1 && c == BCOL-1));
  endtask

  // Launch one frame now and follow it cycle by cycle until done (or until a mid-frame reset).
  task automatic run_frame(input logic [2:0][2:0][31:0] arr, input int stall_idx, input int stall_len,
                           input bit zero_after, input bit start_mid, input int rst_idx);
    sys   = arr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy1, 1);
    chk("done_low_after_start", done1, 0);
    for (int k = 0; k < LAT; k++) begin
      chk("valid_during_wait", valid1, 0);
      tick();
    end
    if (zero_after) sys = '0;
    for (int idx = 0; idx < AROW*BCOL; idx++) begin
      int r = idx / BCOL;
      int c = idx % BCOL;
      if (idx == rst_idx) begin
        rst = 1'b0;
        tick();
        chk("rst_valid", valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_overrun", ovr1, 0);
        chk("rst_data", data1, 0);
        rst = 1'b1;
        ovr_exp = 1'b0;
        return;
      end
      if (idx == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_elem(r, c, arr);
          tick();
        end
        out_ready = 1'b1;
      end
      check_elem(r, c, arr);
      if (start_mid && idx == 4) begin
        start = 1'b1;
        ovr_exp = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("done_pulse", done1, 1);
    chk("valid_after_last", valid1, 0);
    chk("busy_after_last", busy1, 0);
    chk("overrun", ovr1, ovr_exp);
    chk("overrun_norelu", ovr0, ovr_exp);
  endtask

  function automatic logic [2:0][2:0][31:0] rand_arr();
    logic [2:0][2:0][31:0] a;
    for (int r = 0; r < AROW; r++) begin
      for (int c = 0; c < BCOL; c++) begin
        logic [31:0] v = $urandom;
        if ($urandom_range(0, 2) != 0) v = 32'($signed(v) >>> 12);
        a[r][c] = v;
      end
    end
    return a;
  endfunction

  initial begin
    logic [2:0][2:0][31:0] arr;
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    sys = '0;
    tick();
    tick();
    rst = 1'b1;

    // Idle after reset: nothing moves without start.
    for (int k = 0; k < 20; k++) begin
      chk("idle_busy", busy1, 0);
      chk("idle_valid", valid1, 0);
      chk("idle_done", done1, 0);
      chk("idle_overrun", ovr1, 0);
      chk("idle_data", data1, 0);
      tick();
    end

    // Latency and row-major order: values 1..9.
    for (int r = 0; r < AROW; r++)
      for (int c = 0; c < BCOL; c++)
        arr[r][c] = 32'((r*3 + c + 1) * 256);
    run_frame(arr, -1, 0, 1'b0, 1'b0, -1);
    tick();
    chk("done_one_cycle", done1, 0);

    // Saturation / ReLU corners, stall on (1,1), array cleared after capture.
    arr = rand_arr();
    arr[0][0] = 32'h0000_0380;
    arr[0][1] = 32'hFFFF_FF00;
    arr[0][2] = 32'h7FFF_FFFF;
    arr[1][0] = 32'h8000_0000;
    run_frame(arr, 4, 3, 1'b1, 1'b0, -1);
    tick();

    // Overrun during stream, then start in the done cycle.
    run_frame(rand_arr(), -1, 0, 1'b0, 1'b1, -1);
    run_frame(rand_arr(), $urandom_range(0, 8), $urandom_range(1, 4), 1'b0, 1'b0, -1);
    tick();

    // Reset after four handshakes, then a clean full frame.
    run_frame(rand_arr(), -1, 0, 1'b0, 1'b0, 4);
    run_frame(rand_arr(), -1, 0, 1'b0, 1'b0, -1);
    tick();

    // Random frames with random stalls.
    for (int f = 0; f < 8; f++) begin
      run_frame(rand_arr(), $urandom_range(0, 8), $urandom_range(0, 5), 1'b0, 1'b0, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
